// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl
//   Frame sequencer for the registered BCD tens/units splitter in the
//   time-display path. Each frame it snapshots N_BYTES packed BCD bytes and
//   presents them one at a time on ent_o. After waiting out the splitter's
//   register latency, it shows the returned tens and units nibbles on the
//   shared digit bus. The anode select is one-hot, active-low, and is blanked
//   for one cycle between digits.
//
// Parameters
//   N_BYTES : packed BCD bytes per frame (2 digits each), >= 1
//   PRESC   : clk_i cycles each digit is lit, >= 1
//
// Ports
//   clk_i   : system clock, rising edge
//   rst_i   : asynchronous active-high reset
//   en_i    : scan enable, sampled in IDLE and at frame end
//   byte_i  : packed BCD bytes, byte k = byte_i[8k+7:8k], byte N_BYTES-1 is MS
//   ent_o   : byte presented to the splitter
//   dec_i   : splitter tens nibble (1-cycle registered)
//   uni_i   : splitter units nibble
//   digit_o : BCD digit to the segment decoder
//   an_o    : anode enables, active-low; bit 2k+1 = tens of byte k, 2k = units
//   frame_o : one-cycle pulse at frame completion
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, the tens digit of byte N_BYTES-1 is kept dark if it is 0.

module bcd_scan_ctrl #(
  parameter int N_BYTES = 3,
  parameter int PRESC   = 50000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [8*N_BYTES-1:0]   byte_i,
  output logic [7:0]             ent_o,
  input  logic [3:0]             dec_i,
  input  logic [3:0]             uni_i,
  output logic [3:0]             digit_o,
  output logic [2*N_BYTES-1:0]   an_o,
  output logic                   frame_o
);

  localparam int CW = $clog2(PRESC + 1);
  localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(N_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHOW, BLANK} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [KW-1:0]          k, k_n;
  logic                   tens, tens_n;
  logic [8*N_BYTES-1:0]   shadow, shadow_n;
  logic [7:0]             ent_n;
  logic [3:0]             digit_n;
  logic [2*N_BYTES-1:0]   an_n;
  logic                   frame_n;

  function automatic logic [2*N_BYTES-1:0] an_sel(input logic [KW-1:0] kk,
                                                  input logic t);
    logic [2*N_BYTES-1:0] a;
    a = '1;
    for (int unsigned i = 0; i < 2*N_BYTES; i++)
      if (i == 2*int'(kk) + int'(t)) a[i] = 1'b0;
    return a;
  endfunction

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    k_n      = k;
    tens_n   = tens;
    shadow_n = shadow;
    ent_n    = ent_o;
    digit_n  = digit_o;
    an_n     = an_o;
    frame_n  = 1'b0;
    case (state)
      IDLE: begin
        an_n = '1;
        if (en_i) begin
          shadow_n = byte_i;
          k_n      = K_TOP;
          tens_n   = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        ent_n   = shadow[8*int'(k) +: 8];
        cnt_n   = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        // Two cycles: the splitter registers ent_o, then dec_i/uni_i are valid.
        if (cnt == CW'(1)) begin
          cnt_n   = '0;
          digit_n = dec_i;
          an_n    = an_sel(k, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
          // Only the first slot of a frame enters SHOW as tens of K_TOP.
          if ((k == K_TOP) && (dec_i == 4'd0)) an_n = '1;
`endif
          state_n = SHOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (cnt == CW'(PRESC - 1)) begin
          cnt_n   = '0;
          an_n    = '1;
          state_n = BLANK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BLANK: begin
        if (tens) begin
          // Units of the same byte are already on uni_i; no reload needed.
          tens_n  = 1'b0;
          digit_n = uni_i;
          an_n    = an_sel(k, 1'b0);
          state_n = SHOW;
        end else if (k != '0) begin
          k_n     = k - 1'b1;
          tens_n  = 1'b1;
          state_n = LOAD;
        end else begin
          frame_n  = 1'b1;
          shadow_n = byte_i;
          k_n      = K_TOP;
          tens_n   = 1'b1;
          state_n  = en_i ? LOAD : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= K_TOP;
      tens    <= 1'b1;
      shadow  <= '0;
      ent_o   <= '0;
      digit_o <= '0;
      an_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      k       <= k_n;
      tens    <= tens_n;
      shadow  <= shadow_n;
      ent_o   <= ent_n;
      digit_o <= digit_n;
      an_o    <= an_n;
      frame_o <= frame_n;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Testbench for bcd_scan_ctrl (N_BYTES=3, PRESC=4) with a behavioural
// registered splitter model. Each frame is 39 cycles, and each byte takes 13:
//   offset 0 LOAD, 1-2 SETTLE, 3-6 tens lit, 7 blank, 8-11 units lit, 12 blank.
module tb_bcd_scan_ctrl;
  localparam int NB = 3;
  localparam int P  = 4;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [23:0] bytes;
  logic [7:0]  ent;
  logic [3:0]  dec, uni, digit;
  logic [5:0]  an;
  logic        frame;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_scan_ctrl #(.N_BYTES(NB), .PRESC(P)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .byte_i(bytes), .ent_o(ent),
    .dec_i(dec), .uni_i(uni), .digit_o(digit), .an_o(an), .frame_o(frame)
  );

  // Splitter model: registered tens/units of ent.
  always @(posedge clk) begin
    dec <= ent[7:4];
    uni <= ent[3:0];
  end

  typedef struct {
    logic [23:0] bytes;
    logic [23:0] digits;
    bit          lz;
  } vec_t;

  vec_t       vt [4];
  logic [5:0] an_tab [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge sampling point of frame offset 0. Returns at
  // offset 0 of the following frame.
  task automatic check_frame(input logic [23:0] bv, input logic [23:0] dv,
                             input bit lz, input bit pulse0, input int chg_t,
                             input logic [23:0] chg_v, input int drop_t);
    bit lz_on;
`ifdef LEADING_ZERO_BLANK_EN
    lz_on = lz;
`else
    lz_on = 1'b0;
`endif
    for (int t = 0; t < 39; t++) begin
      int p, o, slot;
      logic [5:0] exp_an;
      p = t / 13;
      o = t % 13;
      slot = 2*p + ((o >= 8) ? 1 : 0);
      chk("frame_o", {31'd0, frame}, (t == 0) ? {31'd0, pulse0} : 32'd0);
      if (o >= 1) chk("ent_o", {24'd0, ent}, {24'd0, bv[8*(2-p) +: 8]});
      if ((o >= 3 && o <= 6) || (o >= 8 && o <= 11)) begin
        exp_an = (lz_on && slot == 0) ? 6'b111111 : an_tab[slot];
        chk("an_lit", {26'd0, an}, {26'd0, exp_an});
        chk("digit_lit", {28'd0, digit}, {28'd0, dv[4*(5-slot) +: 4]});
      end else begin
        chk("an_off", {26'd0, an}, 32'h3f);
        if (o == 7 || o == 12)
          chk("digit_hold", {28'd0, digit}, {28'd0, dv[4*(5-slot) +: 4]});
      end
      if (t == chg_t)  bytes = chg_v;
      if (t == drop_t) en = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    an_tab = '{6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
    vt[0] = '{24'h123456, 24'h123456, 1'b0};
    vt[1] = '{24'h999999, 24'h999999, 1'b0};
    vt[2] = '{24'h053412, 24'h053412, 1'b1};
    vt[3] = '{24'h00A0F9, 24'h00A0F9, 1'b1};

    // Reset asserted before any clock edge: outputs settle immediately.
    rst = 1'b1; en = 1'b0; bytes = vt[0].bytes;
    #2;
    chk("rst_an",    {26'd0, an},    32'h3f);
    chk("rst_digit", {28'd0, digit}, 32'd0);
    chk("rst_ent",   {24'd0, ent},   32'd0);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_an", {26'd0, an}, 32'h3f);
    end

    // Back-to-back frames. The next vector is loaded mid-frame (digit-3 slot);
    // the last frame drops en_i during byte 1 tens.
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check_frame(vt[i].bytes, vt[i].digits, vt[i].lz, i > 0,
                  (i < 3) ? 16 : -1, (i < 3) ? vt[i+1].bytes : 24'd0,
                  (i == 3) ? 16 : -1);

    // Frame completed after en_i dropped: pulse, then IDLE dark.
    chk("stop_frame", {31'd0, frame}, 32'd1);
    chk("stop_an",    {26'd0, an},    32'h3f);
    repeat (3) begin
      @(negedge clk);
      chk("stop_idle_an",    {26'd0, an},    32'h3f);
      chk("stop_idle_frame", {31'd0, frame}, 32'd0);
    end

    // Restart from IDLE: first anode low at offset 3 (checked in the frame).
    bytes = 24'h654321;
    en = 1'b1;
    @(negedge clk);
    check_frame(24'h654321, 24'h654321, 1'b0, 1'b0, -1, 24'd0, -1);
    chk("cont_frame", {31'd0, frame}, 32'd1);

    // Async reset in the middle of the first SHOW slot.
    repeat (4) @(negedge clk);
    chk("pre_rst_an", {26'd0, an}, 32'h1f);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_an",    {26'd0, an},    32'h3f);
    chk("mid_rst_digit", {28'd0, digit}, 32'd0);
    chk("mid_rst_ent",   {24'd0, ent},   32'd0);
    chk("mid_rst_frame", {31'd0, frame}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("held_rst_an", {26'd0, an}, 32'h3f);
    bytes = 24'h987650;
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);
    check_frame(24'h987650, 24'h987650, 1'b0, 1'b0, -1, 24'd0, 16);
    chk("end_frame", {31'd0, frame}, 32'd1);
    @(negedge clk);
    chk("end_idle_an", {26'd0, an}, 32'h3f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
